dom_and_pipe: RTL
=================

// Module: dom_and_pipe
// PURPOSE
//  Pipelined d-th order masked AND gadget (DOM-indep), WIDTH bits wide, SHARES=d+1 shares.
//  Built only from BUF/NOT/AND/XOR/DFF-mappable logic, so the synthesised netlist maps onto the
//  PROLEAD cell set and can be evaluated for probing leakage.
//  Sits between the share-splitting front end and the masked S-box/round datapath.
//  Fresh randomness comes from the external PRNG on rand_i, consumed one word per accepted beat.
// PARAMETERS
//  SHARES  2  number of shares (d+1); legal range 2..4
//  WIDTH   1  number of independent AND lanes
//  NRAND   WIDTH*SHARES*(SHARES-1)/2  derived, randomness bits per beat; do not override
// PORTS
//  clk        in   1              single clock, rising edge
//  rst        in   1              synchronous, active-high reset
//  in_valid   in   1              beat on a_i/b_i/rand_i is valid
//  in_ready   out  1              gadget accepts the beat this cycle
//  a_i        in   SHARES*WIDTH   shares of a; share s in bits [s*WIDTH +: WIDTH]
//  b_i        in   SHARES*WIDTH   shares of b, same layout
//  rand_i     in   NRAND          fresh mask bits; pair (i<j) lane k at [(pair_idx(i,j))*WIDTH + k]
//  out_valid  out  1              q_o holds a valid result
//  out_ready  in   1              consumer accepts q_o this cycle
//  q_o        out  SHARES*WIDTH   shares of q = a & b, same layout as a_i
// BEHAVIOUR
//  - Reset (rst=1 at a rising edge): all valid flags 0, all share registers and q_o 0; in_ready reads 1 next cycle.
//  - Two register stages S1 (resharing) and S2 (compression/output). Latency exactly 2 cycles with no stall.
//  - Load rules: ld2 = v1 & (~v2 | out_ready); ld1 = ~v1 | ld2; in_ready = ld1 (combinational from state + out_ready).
//  - Accept when in_valid & in_ready. S1 loads: inner t_ii = a_i&b_i; for i<j: z_ij = (a_i&b_j)^r_ij,
//    z_ji = (a_j&b_i)^r_ij. Every cross term is registered BEFORE any XOR with other terms.
//  - S2 loads: q_i = t_ii ^ XOR_{j!=i} z_ij, from S1 registers only.
//  - Data registers load ONLY on their stage's load; otherwise hold (no toggling on bubbles/stalls).
//  - v1 next: accept ? 1 : (ld2 ? 0 : v1). v2 next: ld2 ? 1 : (out_ready ? 0 : v2).
//  - Full pipe + out_ready=1 + in_valid=1: both stages advance same cycle, throughput 1 beat/cycle.
//  - Full pipe + out_ready=0: in_ready=0, q_o and all registers stable; no beat lost or duplicated.
//  - out_valid=1 and out_ready=0 => q_o unchanged next cycle (AXI-style hold).
//  - rst mid-operation discards in-flight beats; rand_i bits of discarded beats are not reused.
//  - rand_i sampled only on accept; XOR of q_o shares equals AND of XOR(a) and XOR(b) per lane.
//  - No combinational path from a_i/b_i/rand_i to q_o; out_ready->in_ready is the only comb path through.
// STRUCTURE
//  - Package dom_pkg: function nrand(shares,width), function pair_idx(i,j) (i<j, lexicographic,
//    0..SHARES*(SHARES-1)/2-1), localparam MAX_SHARES=4.
//  - One sub-module dom_cross_reg: one (i,j) pair, WIDTH lanes: AND, XOR with r_ij, register with load enable.
//    Top instantiates SHARES*(SHARES-1) of them plus SHARES inner-term registers via generate.
//  - Handshake/valid logic kept in the top, separate from share datapath (leakage review readability).
// TESTING
//  1 Reset: hold rst 3 cycles with in_valid=1 -> out_valid=0, q_o=0, in_ready=1 the cycle after rst drops.
//  2 SHARES=2,WIDTH=1: a=(1,0), b=(1,1), r=1, out_ready=1 -> 2 cycles later out_valid=1, q0^q1=0;
//    a=(1,0), b=(0,1) -> q0^q1=1; sweep all 16 share pairs x r in {0,1}, check XOR and per-share values.
//  3 Streaming: in_valid=1 for 20 cycles, out_ready=1 -> 20 results in order, in_ready never drops.
//  4 Backpressure: fill pipe, out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, q_o stable,
//    then out_ready=1 -> remaining beats emerge in order, none duplicated.
//  5 Reset mid-flight: rst on cycle after 2 accepts -> out_valid never asserts for those beats.
//  6 SHARES=3,WIDTH=8 random constrained test vs reference model (XOR-of-shares), 10k beats, random ready/valid.

Source files
------------

// File: rtl/dom_and_pipe_pkg.sv
// Shared helpers for the DOM-indep masked AND gadget: randomness sizing and
// the lexicographic (i<j) pair numbering used to slice rand_i.
package dom_pkg;

  localparam int unsigned MAX_SHARES = 4;

  // Fresh mask bits consumed per accepted beat.
  function automatic int unsigned nrand(input int unsigned shares,
                                        input int unsigned width);
    return width * shares * (shares - 1) / 2;
  endfunction

  // Lexicographic index of pair (i,j), i<j, among all pairs of 'shares' shares:
  // (0,1)=0, (0,2)=1, ..., (1,2)=shares-1, ...
  function automatic int unsigned pair_idx(input int unsigned i,
                                           input int unsigned j,
                                           input int unsigned shares);
    return i * shares - (i * (i + 1)) / 2 + (j - i - 1);
  endfunction

endpackage

// File: rtl/dom_and_pipe_cross_reg.sv
// One DOM cross term for a share pair, WIDTH lanes: z = (a & b) ^ r, registered
// on its own before it meets any other term.
module dom_cross_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] z
);

  // Resharing register: loads only on the stage load, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      z <= '0;
    end else if (ld) begin
      z <= (a & b) ^ r;
    end
  end

endmodule

// File: rtl/dom_and_pipe.sv
// Pipelined d-th order DOM-indep masked AND: stage 1 reshares (inner and cross
// terms registered separately), stage 2 compresses each share row into q_o.
module dom_and_pipe
  import dom_pkg::*;
#(
  parameter int unsigned SHARES = 2,
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned NRAND  = nrand(SHARES, WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SHARES*WIDTH-1:0] a_i,
  input  logic [SHARES*WIDTH-1:0] b_i,
  input  logic [NRAND-1:0]        rand_i,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SHARES*WIDTH-1:0] q_o
);

  // ---------------------------------------------------------------------------
  // Handshake / valid control (kept apart from the share datapath)
  // ---------------------------------------------------------------------------
  logic v1, v2;
  logic ld1, ld2, accept;

  // Stage loads: S2 takes S1 when its slot is empty or drained this cycle.
  always_comb begin
    ld2    = v1 & (~v2 | out_ready);
    ld1    = ~v1 | ld2;
    accept = in_valid & ld1;
  end

  assign in_ready  = ld1;
  assign out_valid = v2;

  // Valid flags for both stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      v1 <= accept ? 1'b1 : (ld2 ? 1'b0 : v1);
      v2 <= ld2 ? 1'b1 : (out_ready ? 1'b0 : v2);
    end
  end

  // ---------------------------------------------------------------------------
  // Share datapath
  // ---------------------------------------------------------------------------
  // Term (i,j) lives at terms[(i*SHARES+j)*WIDTH +: WIDTH]; the diagonal holds
  // the inner products so compression is a plain XOR across each row.
  logic [SHARES*SHARES*WIDTH-1:0] terms;

  for (genvar i = 0; i < SHARES; i++) begin : g_row
    for (genvar j = 0; j < SHARES; j++) begin : g_col
      if (i == j) begin : g_inner
        logic [WIDTH-1:0] t_q;

        // Inner term a_i & b_i, needs no fresh mask.
        always_ff @(posedge clk) begin
          if (rst) begin
            t_q <= '0;
          end else if (accept) begin
            t_q <= a_i[i*WIDTH +: WIDTH] & b_i[i*WIDTH +: WIDTH];
          end
        end

        assign terms[(i*SHARES+j)*WIDTH +: WIDTH] = t_q;
      end else begin : g_cross
        // z_ij and z_ji share the mask of the unordered pair {i,j}.
        localparam int unsigned LO = (i < j) ? i : j;
        localparam int unsigned HI = (i < j) ? j : i;
        localparam int unsigned P  = pair_idx(LO, HI, SHARES);

        dom_cross_reg #(
          .WIDTH(WIDTH)
        ) u_cross (
          .clk (clk),
          .rst (rst),
          .ld  (accept),
          .a   (a_i[i*WIDTH +: WIDTH]),
          .b   (b_i[j*WIDTH +: WIDTH]),
          .r   (rand_i[P*WIDTH +: WIDTH]),
          .z   (terms[(i*SHARES+j)*WIDTH +: WIDTH])
        );
      end
    end
  end

  logic [SHARES*WIDTH-1:0] q_next;

  // Compression: each output share is the XOR of its registered term row.
  always_comb begin
    q_next = '0;
    for (int unsigned s = 0; s < SHARES; s++) begin
      for (int unsigned j = 0; j < SHARES; j++) begin
        q_next[s*WIDTH +: WIDTH] = q_next[s*WIDTH +: WIDTH]
                                 ^ terms[(s*SHARES+j)*WIDTH +: WIDTH];
      end
    end
  end

  // Output share register: loads only on the S2 load, holds under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_o <= '0;
    end else if (ld2) begin
      q_o <= q_next;
    end
  end

endmodule
